// File: rtl/router_fsm_multi.sv
// Router controller FSM for NUM_PORTS destination FIFOs.
// Optional WTE abandon timer: define ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm_multi #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 32
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic [NUM_PORTS-1:0] dest_sel,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 ld_state,
  output logic                 lfd_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic                 drop_state,
  output logic                 wait_timeout
);

  localparam int NP2 = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] NP_L = (ADDR_W + 1)'(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > NP2 || WAIT_TIMEOUT < 2)
  begin : g_bad_param
    $error("router_fsm_multi: illegal parameters");
  end

  typedef enum logic [3:0] {
    S_DA,
    S_LFD,
    S_LD,
    S_LP,
    S_CPE,
    S_FFS,
    S_LAF,
    S_WTE,
    S_DROP
  } state_e;

  state_e state, state_n;

  logic [ADDR_W-1:0] dest;
  logic              dest_vld;
  logic [NP2-1:0]    emp_pad;
  logic [NP2-1:0]    full_pad;
  logic [NP2-1:0]    sr_pad;
  logic [NP2-1:0]    sel_pad;
  logic              addr_ok;
  logic              full;
  logic              empty;
  logic              sr_hit;
  logic              tmo;

  // Widen the per-port flags so any address can index them safely.
  always_comb begin
    emp_pad  = '0;
    full_pad = '0;
    sr_pad   = '0;
    emp_pad[NUM_PORTS-1:0]  = fifo_empty;
    full_pad[NUM_PORTS-1:0] = fifo_full;
    sr_pad[NUM_PORTS-1:0]   = soft_reset;
  end

  assign addr_ok = pkt_valid && ({1'b0, data_in} < NP_L);
  assign full    = dest_vld && full_pad[dest];
  assign empty   = dest_vld && emp_pad[dest];
  assign sr_hit  = dest_vld && sr_pad[dest];

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_TIMEOUT) + 1;
  logic [CW-1:0] wcnt;

  assign tmo = (state == S_WTE) &&
               (wcnt == CW'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wcnt <= '0;
    end else if (state != S_WTE || sr_hit) begin
      wcnt <= '0;
    end else if (!tmo) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_DA;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    wait_timeout = 1'b0;
    unique case (state)
      S_DA: begin
        if (pkt_valid) begin
          if (!addr_ok) begin
            state_n = S_DROP;
          end else if (emp_pad[data_in]) begin
            state_n = S_LFD;
          end else begin
            state_n = S_WTE;
          end
        end
      end
      S_LFD: state_n = S_LD;
      S_LD: begin
        if (full) begin
          state_n = S_FFS;
        end else if (!pkt_valid) begin
          state_n = S_LP;
        end
      end
      S_LP: state_n = S_CPE;
      S_CPE: state_n = full ? S_FFS : S_DA;
      S_FFS: begin
        if (!full) begin
          state_n = S_LAF;
        end
      end
      S_LAF: begin
        if (parity_done) begin
          state_n = S_DA;
        end else if (low_pkt_valid) begin
          state_n = S_LP;
        end else begin
          state_n = S_LD;
        end
      end
      S_WTE: begin
        if (empty) begin
          state_n = S_LFD;
        end else if (tmo) begin
          state_n      = S_DROP;
          wait_timeout = 1'b1;
        end
      end
      S_DROP: begin
        if (!pkt_valid) begin
          state_n = S_DA;
        end
      end
      default: state_n = S_DA;
    endcase
    // Read-side soft reset on the held port aborts the packet.
    if (sr_hit && state != S_DA && state != S_DROP) begin
      state_n      = S_DA;
      wait_timeout = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dest     <= '0;
      dest_vld <= 1'b0;
    end else if (state == S_DA && addr_ok) begin
      dest     <= data_in;
      dest_vld <= 1'b1;
    end else if (state_n == S_DA) begin
      dest     <= '0;
      dest_vld <= 1'b0;
    end
  end

  always_comb begin
    sel_pad = '0;
    if (dest_vld) begin
      sel_pad[dest] = 1'b1;
    end
  end

  assign dest_sel = sel_pad[NUM_PORTS-1:0];

  assign detect_add    = (state == S_DA);
  assign ld_state      = (state == S_LD);
  assign lfd_state     = (state == S_LFD);
  assign laf_state     = (state == S_LAF);
  assign full_state    = (state == S_FFS);
  assign rst_int_reg   = (state == S_CPE);
  assign drop_state    = (state == S_DROP);
  assign write_enb_reg = (state == S_LD) || (state == S_LP) ||
                         (state == S_LAF);
  assign busy = (state == S_LFD) || (state == S_LP) ||
                (state == S_CPE) || (state == S_FFS) ||
                (state == S_LAF) || (state == S_WTE);

endmodule

// File: tb/tb_router_fsm_multi.sv
// Bench for router_fsm_multi: 4-port instance (a) and 3-port instance (b).
// Vector table plus scoreboard queue of expected decodes.
module tb_router_fsm_multi;

  typedef enum {DA, LFD, LD, LP, CPE, FFS, LAF, WTE, DRP} st_e;

  typedef struct {
    st_e        st;
    logic [3:0] ds;
    logic       pv;
    logic [1:0] d;
    logic [3:0] emp;
    logic [3:0] full;
    logic [3:0] sr;
    logic       pd;
    logic       lpv;
    logic       rn;
    bit         b;
    logic       wt;
  } vec_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       a_pv = 1'b0;
  logic       b_pv = 1'b0;
  logic [1:0] data_in = '0;
  logic [3:0] fifo_empty = 4'hF;
  logic [3:0] fifo_full = '0;
  logic [3:0] soft_reset = '0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;

  logic [3:0] a_ds;
  logic [2:0] b_ds;
  logic a_busy, a_da, a_ld, a_lfd, a_laf, a_ffs, a_wer, a_cpe, a_drp, a_wt;
  logic b_busy, b_da, b_ld, b_lfd, b_laf, b_ffs, b_wer, b_cpe, b_drp, b_wt;
  logic [13:0] a_out, b_out;

  int nvec = 0;
  int nmis = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clock = ~clock;

  router_fsm_multi #(.NUM_PORTS(4), .ADDR_W(2), .WAIT_TIMEOUT(8)) u_a (
    .clock(clock), .resetn(resetn), .pkt_valid(a_pv),
    .data_in(data_in), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .dest_sel(a_ds), .busy(a_busy), .detect_add(a_da),
    .ld_state(a_ld), .lfd_state(a_lfd), .laf_state(a_laf),
    .full_state(a_ffs), .write_enb_reg(a_wer),
    .rst_int_reg(a_cpe), .drop_state(a_drp),
    .wait_timeout(a_wt)
  );

  router_fsm_multi #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(8)) u_b (
    .clock(clock), .resetn(resetn), .pkt_valid(b_pv),
    .data_in(data_in), .fifo_empty(fifo_empty[2:0]),
    .fifo_full(fifo_full[2:0]), .soft_reset(soft_reset[2:0]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .dest_sel(b_ds), .busy(b_busy), .detect_add(b_da),
    .ld_state(b_ld), .lfd_state(b_lfd), .laf_state(b_laf),
    .full_state(b_ffs), .write_enb_reg(b_wer),
    .rst_int_reg(b_cpe), .drop_state(b_drp),
    .wait_timeout(b_wt)
  );

  assign a_out = {a_da, a_ld, a_lfd, a_laf, a_ffs, a_wer, a_cpe,
                  a_busy, a_drp, a_wt, a_ds};
  assign b_out = {b_da, b_ld, b_lfd, b_laf, b_ffs, b_wer, b_cpe,
                  b_busy, b_drp, b_wt, 1'b0, b_ds};

  function automatic logic [13:0] exp_o(st_e s, logic [3:0] ds,
                                        logic wt);
    logic bsy, wer;
    bsy = (s == LFD) || (s == LP) || (s == CPE) || (s == FFS) ||
          (s == LAF) || (s == WTE);
    wer = (s == LD) || (s == LP) || (s == LAF);
    return {s == DA, s == LD, s == LFD, s == LAF, s == FFS, wer,
            s == CPE, bsy, s == DRP, wt, ds};
  endfunction

  function automatic vec_t mk(st_e st, logic [3:0] ds, logic pv = 0,
                              logic [1:0] d = 0, logic [3:0] emp = 4'hF,
                              logic [3:0] full = 0, logic [3:0] sr = 0,
                              logic pd = 0, logic lpv = 0, logic rn = 1,
                              bit b = 0, logic wt = 0);
    vec_t v;
    v.st = st; v.ds = ds; v.pv = pv; v.d = d; v.emp = emp;
    v.full = full; v.sr = sr; v.pd = pd; v.lpv = lpv; v.rn = rn;
    v.b = b; v.wt = wt;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    logic [13:0] exp, got;
    @(negedge clock);
    resetn        = v.rn;
    a_pv          = v.b ? 1'b0 : v.pv;
    b_pv          = v.b ? v.pv : 1'b0;
    data_in       = v.d;
    fifo_empty    = v.emp;
    fifo_full     = v.full;
    soft_reset    = v.sr;
    parity_done   = v.pd;
    low_pkt_valid = v.lpv;
    sb.push_back(v);
    @(posedge clock);
    #1;
    e   = sb.pop_front();
    exp = exp_o(e.st, e.ds, e.wt);
    got = e.b ? b_out : a_out;
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL vec%0d dut_%s st=%s got=%b want=%b",
               nvec, e.b ? "b" : "a", e.st.name(), got, exp);
    end
  endtask

  initial begin
    // reset, then addr 3 with 5 payload bytes
    tbl.push_back(mk(DA, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0));
    tbl.push_back(mk(LFD, 8, 1, 3));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(LD, 8, 1));
    tbl.push_back(mk(LP, 8, 0));
    tbl.push_back(mk(CPE, 8, 0));
    tbl.push_back(mk(DA, 0, 0));
    // addr 2 waits 4 cycles for empty
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(WTE, 4, 1, 2, 4'b1011));
    tbl.push_back(mk(LFD, 4, 1, 2));
    tbl.push_back(mk(LD, 4, 1));
    tbl.push_back(mk(LP, 4, 0));
    tbl.push_back(mk(CPE, 4, 0));
    tbl.push_back(mk(DA, 0, 0));
    // full for 3 cycles, low_pkt_valid at release
    tbl.push_back(mk(LFD, 2, 1, 1));
    tbl.push_back(mk(LD, 2, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(FFS, 2, 1, 0, 4'hF, 4'b0010));
    tbl.push_back(mk(LAF, 2, 0));
    tbl.push_back(mk(LP, 2, 0, 0, 4'hF, 0, 0, 0, 1));
    tbl.push_back(mk(CPE, 2, 0));
    tbl.push_back(mk(DA, 0, 0));
    // soft reset: other port ignored, own port aborts
    tbl.push_back(mk(LFD, 2, 1, 1));
    tbl.push_back(mk(LD, 2, 1));
    tbl.push_back(mk(LD, 2, 1, 0, 4'hF, 0, 4'b0001));
    tbl.push_back(mk(DA, 0, 1, 0, 4'hF, 0, 4'b0010));
    tbl.push_back(mk(DA, 0, 0));
    // only the latched port's full flag matters
    tbl.push_back(mk(LFD, 1, 1, 0));
    tbl.push_back(mk(LD, 1, 1));
    tbl.push_back(mk(LD, 1, 1, 0, 4'hF, 4'b1110));
    tbl.push_back(mk(LP, 1, 0, 0, 4'hF, 4'b1110));
    tbl.push_back(mk(CPE, 1, 0, 0, 4'hF, 4'b0001));
    tbl.push_back(mk(FFS, 1, 0, 0, 4'hF, 4'b0001));
    tbl.push_back(mk(LAF, 1, 0));
    tbl.push_back(mk(DA, 0, 0, 0, 4'hF, 0, 0, 1));
    // full beats pkt_valid falling; LAF falls back to LD
    tbl.push_back(mk(LFD, 8, 1, 3));
    tbl.push_back(mk(LD, 8, 1));
    tbl.push_back(mk(FFS, 8, 0, 0, 4'hF, 4'b1000));
    tbl.push_back(mk(LAF, 8, 0));
    tbl.push_back(mk(LD, 8, 0));
    tbl.push_back(mk(LP, 8, 0));
    tbl.push_back(mk(CPE, 8, 0));
    tbl.push_back(mk(DA, 0, 0));
    tbl.push_back(mk(DA, 0, 0, 0, 4'hF, 0, 4'hF));
    // 3-port instance: addr 3 is dropped
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(DRP, 0, 1, 3, 4'hF, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(DA, 0, 0, 0, 4'hF, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(LFD, 4, 1, 2, 4'hF, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(DA, 0, 0, 0, 4'hF, 0, 4'b0100, 0, 0, 1, 1));

    foreach (tbl[i]) apply(tbl[i]);

    // never-draining destination
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    for (int i = 0; i < 7; i++)
      apply(mk(WTE, 1, 1, 0, 4'b1110));
    apply(mk(WTE, 1, 1, 0, 4'b1110, 0, 0, 0, 0, 1, 0, 1));
    apply(mk(DRP, 1, 1, 0, 4'b1110));
    apply(mk(DRP, 1, 1, 0, 4'b1110));
    apply(mk(DA, 0, 0));
`else
    for (int i = 0; i < 100; i++)
      apply(mk(WTE, 1, 1, 0, 4'b1110));
    apply(mk(DA, 0, 0, 0, 4'b1110, 0, 4'b0001));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/router_fsm_multi.md
Name: router_fsm_multi

Overview:
- Parametrised successor to the router's 3-port controller FSM; sits between the router register block and the NUM_PORTS destination FIFOs.
- Decodes the header address and sequences header, payload and parity loading.
- Handles full/empty back-pressure and per-port soft reset for an arbitrary number of output ports.
- New behaviour: discards packets whose address is out of range, and optionally abandons a destination whose FIFO never drains.

Parameters:
- NUM_PORTS, 3: number of destination FIFOs; legal range 2..2**ADDR_W.
- ADDR_W, 2: width of the header address field in data_in.
- WAIT_TIMEOUT, 32: cycles spent in WAIT_TILL_EMPTY before abandoning. Used only with the optional feature; must be ≥ 2.

Ports:
- clock, in, 1: system clock; all state updates on its rising edge.
- resetn, in, 1: synchronous, active-low reset.
- pkt_valid, in, 1: source packet valid; its high-to-low transition marks the parity byte.
- data_in, in, ADDR_W: header address bits, sampled in DECODE_ADDRESS.
- fifo_empty, in, NUM_PORTS: per-port FIFO empty flags.
- fifo_full, in, NUM_PORTS: per-port FIFO full flags.
- soft_reset, in, NUM_PORTS: per-port soft reset from read-side timeout.
- parity_done, in, 1: register block has stored parity.
- low_pkt_valid, in, 1: register block saw pkt_valid fall while full.
- dest_sel, out, NUM_PORTS: one-hot latched destination; zero when no destination is held.
- busy, out, 1: stall source.
- detect_add, ld_state, lfd_state, laf_state, full_state, write_enb_reg, rst_int_reg, out, 1 each: state decodes to the register block.
- drop_state, out, 1: high while a packet is being discarded.
- wait_timeout, out, 1: one-cycle pulse when a wait is abandoned.

Behaviour:
- States (4-bit encoding):
  - DECODE_ADDRESS
  - LOAD_FIRST_DATA
  - LOAD_DATA
  - LOAD_PARITY
  - CHECK_PARITY_ERROR
  - FIFO_FULL_STATE
  - LOAD_AFTER_FULL
  - WAIT_TILL_EMPTY
  - DROP_PACKET
- Reset (resetn=0 at clock edge):
  - State goes to DECODE_ADDRESS and the dest register clears.
  - Outputs after reset: detect_add=1; all other outputs 0, including dest_sel=0.
- Destination latch: in DECODE_ADDRESS with pkt_valid=1 and data_in<NUM_PORTS, dest<=data_in. The value holds until the FSM re-enters DECODE_ADDRESS, where it clears. It does not clear one cycle after decode.
- Selection: full=fifo_full[dest] and empty=fifo_empty[dest]; only the latched port is ever consulted after decode.
- DECODE_ADDRESS transitions:
  - pkt_valid=1 and data_in≥NUM_PORTS -> DROP_PACKET.
  - Else pkt_valid=1 and fifo_empty[data_in]=1 -> LOAD_FIRST_DATA.
  - Else pkt_valid=1 -> WAIT_TILL_EMPTY.
  - Else stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA: full -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay. Full takes priority when full and pkt_valid falling coincide.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- FIFO_FULL_STATE: stay while full; else -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL, in priority order: parity_done -> DECODE_ADDRESS; low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
- WAIT_TILL_EMPTY: empty -> LOAD_FIRST_DATA; else stay (see optional feature).
- DROP_PACKET: stay while pkt_valid=1; pkt_valid=0 -> DECODE_ADDRESS. The parity byte is consumed and discarded in the last DROP_PACKET cycle.
- Soft reset: soft_reset[dest]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next cycle, overriding every transition. soft_reset on a non-selected port is ignored. Soft reset has no effect in DECODE_ADDRESS or DROP_PACKET.
- Output decodes (Moore, combinational from state only):
  - busy = LFD | LP | CPE | FFS | LAF | WTE. busy=0 in DROP_PACKET, so the source streams freely.
  - write_enb_reg = LD | LP | LAF.
  - detect_add = DA; ld_state = LD; lfd_state = LFD; laf_state = LAF; full_state = FFS; rst_int_reg = CPE; drop_state = DROP.
  - dest_sel = one-hot of dest while dest is valid, else 0.

Optional Feature:
ROUTER_FSM_WAIT_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there. If empty is still 0 when the count reaches WAIT_TIMEOUT-1, the next state is DROP_PACKET and wait_timeout pulses high for that transition cycle. If empty and timeout coincide, empty wins (-> LOAD_FIRST_DATA, no pulse). The counter clears on reset and on soft reset.
- Undefined: no counter; WAIT_TILL_EMPTY waits indefinitely; wait_timeout tied 0.

Test Plan:
- NUM_PORTS=4, ADDR_W=2:
  - Header addr 3 with fifo_empty=4'b1111, 5 payload bytes, then parity -> states DA, LFD, LD×5, LP, CPE, DA; write_enb_reg high 6 cycles; dest_sel=4'b1000 throughout, 0 after.
  - Header addr 2 with fifo_empty[2]=0 for 4 cycles -> WTE×4 then LFD; busy=1 throughout the wait.
- NUM_PORTS=3: header addr 3 (out of range), 4 bytes then pkt_valid low -> DROP_PACKET for 4 cycles; busy=0, write_enb_reg=0, drop_state=1, dest_sel=0; then DA.
- fifo_full[dest] asserted in LD for 3 cycles; low_pkt_valid=1 at release -> LD, FFS×3, LAF, LP, CPE, DA.
- In LD with dest=1: soft_reset[0] pulse -> no effect; soft_reset[1] pulse -> DA next cycle, dest_sel=0.
- Macro defined, WAIT_TIMEOUT=8, fifo_empty[dest] held 0 -> exactly 8 cycles in WTE, single-cycle wait_timeout pulse, then DROP_PACKET. Macro undefined -> still in WTE at cycle 100.
